// File: rtl/graph_pkg.sv
// Shared types and constants for the graph frame scanning logic.
package graph_pkg;

    // Bits per node feature.
    localparam int PRECISION = 8;

    // Edge bits carried in every node word (9 neighbours x 2 bits).
    // A word is tested for emptiness over features plus these bits.
    localparam int EDGE_BITS = 18;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_CHK_A = 3'd2,
        S_CHK_B = 3'd3,
        S_CLEAN = 3'd4
    } scan_state_t;

endpackage

// File: rtl/feature_scanner.sv
// Scans the two most recent frames of a triple-buffered node memory,
// forwards every non-empty node word over a valid/ready stream, then
// zeroes the memory through its clean strobe before signalling frame_done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for mem_switch
// S_RD    | mem_addr presented, read data arrives next cycle
// S_CHK_A | test/forward frame a word (holds until beat accepted)
// S_CHK_B | test/forward frame b word, then next node or clean
// S_CLEAN | mem_clean asserted for N cycles, then frame_done
module feature_scanner #(
    parameter int GRAPH_SIZE  = 32,
    parameter int PRECISION   = graph_pkg::PRECISION,
    parameter int FEATURE_DIM = 16,
    parameter int ADDR_WIDTH  = $clog2(GRAPH_SIZE * GRAPH_SIZE),
    parameter int DATA_WIDTH  = FEATURE_DIM * PRECISION + graph_pkg::EDGE_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_switch,
    input  logic [DATA_WIDTH-1:0] mem_read_a,
    input  logic [DATA_WIDTH-1:0] mem_read_b,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_clean,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_node,
    output logic                  out_sel,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int N  = GRAPH_SIZE * GRAPH_SIZE;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    graph_pkg::scan_state_t state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cln_q, cln_d;
    logic                  pend_q, pend_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_node_q, out_node_d;
    logic                  out_sel_q, out_sel_d;
    logic                  mem_clean_q, mem_clean_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic                  word_a_nz, word_b_nz;
    logic                  advance;

    assign word_a_nz = |mem_read_a;
    assign word_b_nz = |mem_read_b;

    // The scan counter doubles as the read address; it only moves on the
    // way into S_RD, so the read data stays stable while a beat stalls.
    assign mem_addr   = cnt_q[ADDR_WIDTH-1:0];
    assign mem_clean  = mem_clean_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_node   = out_node_q;
    assign out_sel    = out_sel_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= graph_pkg::S_IDLE;
            cnt_q        <= '0;
            cln_q        <= '0;
            pend_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_node_q   <= '0;
            out_sel_q    <= 1'b0;
            mem_clean_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cln_q        <= cln_d;
            pend_q       <= pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_node_q   <= out_node_d;
            out_sel_q    <= out_sel_d;
            mem_clean_q  <= mem_clean_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cln_d        = cln_q;
        pend_d       = pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_node_d   = out_node_q;
        out_sel_d    = out_sel_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        advance      = 1'b0;

        unique case (state_q)
            graph_pkg::S_IDLE: begin
                if (mem_switch) begin
                    state_d = graph_pkg::S_RD;
                    cnt_d   = '0;
                end
            end

            graph_pkg::S_RD: begin
                if (mem_switch) begin
                    overrun_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    state_d = graph_pkg::S_CHK_A;
                end
            end

            graph_pkg::S_CHK_A: begin
                if (mem_switch) begin
                    overrun_d   = 1'b1;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = graph_pkg::S_RD;
                end else if (out_valid_q) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = graph_pkg::S_CHK_B;
                    end
                end else if (word_a_nz) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_read_a;
                    out_node_d  = cnt_q[ADDR_WIDTH-1:0];
                    out_sel_d   = 1'b0;
                end else begin
                    state_d = graph_pkg::S_CHK_B;
                end
            end

            graph_pkg::S_CHK_B: begin
                if (mem_switch) begin
                    overrun_d   = 1'b1;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = graph_pkg::S_RD;
                end else if (out_valid_q) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        advance     = 1'b1;
                    end
                end else if (word_b_nz) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_read_b;
                    out_node_d  = cnt_q[ADDR_WIDTH-1:0];
                    out_sel_d   = 1'b1;
                end else begin
                    advance = 1'b1;
                end

                if (advance) begin
                    if (cnt_q == LAST) begin
                        state_d = graph_pkg::S_CLEAN;
                        cln_d   = '0;
                    end else begin
                        state_d = graph_pkg::S_RD;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end

            graph_pkg::S_CLEAN: begin
                // A switch here is remembered; the clean run is never shortened
                // so the memory's clean address always wraps back to zero.
                if (mem_switch) begin
                    overrun_d = 1'b1;
                    pend_d    = 1'b1;
                end
                if (cln_q == LAST) begin
                    frame_done_d = 1'b1;
                    if (pend_q || mem_switch) begin
                        state_d = graph_pkg::S_RD;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = graph_pkg::S_IDLE;
                    end
                end else begin
                    cln_d = cln_q + CW'(1);
                end
            end

            default: begin
                state_d = graph_pkg::S_IDLE;
            end
        endcase

        mem_clean_d = (state_d == graph_pkg::S_CLEAN);
    end

endmodule

// File: tb/tb_feature_scanner.sv
// Directed bench for feature_scanner on a 4x4 grid (N = 16).
module tb_feature_scanner;

    localparam int GS = 4;
    localparam int N  = GS * GS;
    localparam int AW = 4;
    localparam int DW = 16 * graph_pkg::PRECISION + graph_pkg::EDGE_BITS;

    typedef logic [159:0] val_t;

    typedef struct {
        logic [AW-1:0] node;
        logic [DW-1:0] data;
        logic          sel;
    } beat_t;

    logic          clk;
    logic          reset;
    logic          mem_switch;
    logic [DW-1:0] mem_read_a;
    logic [DW-1:0] mem_read_b;
    logic [AW-1:0] mem_addr;
    logic          mem_clean;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_node;
    logic          out_sel;
    logic          frame_done;
    logic          overrun;

    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];

    int    cyc       = 0;
    int    clean_cnt = 0;
    int    fd_cnt    = 0;
    int    ov_cnt    = 0;
    int    valid_cnt = 0;
    int    sw_cyc    = 0;
    int    fd_cyc    = 0;
    beat_t beats[$];

    int checks = 0;
    int errors = 0;

    feature_scanner #(
        .GRAPH_SIZE (GS),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_switch (mem_switch),
        .mem_read_a (mem_read_a),
        .mem_read_b (mem_read_b),
        .mem_addr   (mem_addr),
        .mem_clean  (mem_clean),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_node   (out_node),
        .out_sel    (out_sel),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame memories with one cycle of read latency.
    always @(posedge clk) begin
        mem_read_a <= mem_a[mem_addr];
        mem_read_b <= mem_b[mem_addr];
    end

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        cyc = cyc + 1;
        if (mem_clean)  clean_cnt = clean_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (out_valid)  valid_cnt = valid_cnt + 1;
        if (mem_switch) sw_cyc = cyc;
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            b.node = out_node;
            b.data = out_data;
            b.sel  = out_sel;
            beats.push_back(b);
        end
    end

    task automatic chk(input string tag, input val_t got, input val_t exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_switch();
        mem_switch = 1'b1;
        tick();
        mem_switch = 1'b0;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    endtask

    task automatic wait_fd(input string tag, input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, val_t'(frame_done), val_t'(1));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, val_t'(out_valid), val_t'(1));
    endtask

    task automatic check_beat(input string tag, input int idx, input int node,
                              input int data, input int sel);
        if (beats.size() > idx) begin
            chk({tag, "_node"}, val_t'(beats[idx].node), val_t'(node));
            chk({tag, "_data"}, val_t'(beats[idx].data), val_t'(data));
            chk({tag, "_sel"},  val_t'(beats[idx].sel),  val_t'(sel));
        end else begin
            chk({tag, "_missing"}, val_t'(beats.size()), val_t'(idx + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bb, cb, fb, ob, vb, n;
        logic [DW-1:0] d0;
        logic [AW-1:0] n0, a0;
        logic          stable;

        reset      = 1'b1;
        mem_switch = 1'b0;
        out_ready  = 1'b1;
        clear_mems();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr",   val_t'(mem_addr),   val_t'(0));
        chk("rst_mem_clean",  val_t'(mem_clean),  val_t'(0));
        chk("rst_out_valid",  val_t'(out_valid),  val_t'(0));
        chk("rst_out_data",   val_t'(out_data),   val_t'(0));
        chk("rst_out_node",   val_t'(out_node),   val_t'(0));
        chk("rst_out_sel",    val_t'(out_sel),    val_t'(0));
        chk("rst_frame_done", val_t'(frame_done), val_t'(0));
        chk("rst_overrun",    val_t'(overrun),    val_t'(0));
        reset = 1'b0;
        tick();
        tick();

        // Two sparse frames: one beat from each.
        mem_a[3] = DW'(5);
        mem_b[9] = DW'(7);
        bb = beats.size(); cb = clean_cnt; fb = fd_cnt; ob = ov_cnt;
        pulse_switch();
        wait_fd("t1_done", 200);
        tick();
        chk("t1_beats", val_t'(beats.size() - bb), val_t'(2));
        check_beat("t1_b0", bb, 3, 5, 0);
        check_beat("t1_b1", bb + 1, 9, 7, 1);
        chk("t1_clean", val_t'(clean_cnt - cb), val_t'(16));
        chk("t1_fd",    val_t'(fd_cnt - fb),    val_t'(1));
        chk("t1_ov",    val_t'(ov_cnt - ob),    val_t'(0));
        tick();

        // Empty frames: 3 cycles per node, 16 clean cycles, registered done.
        // Span counts the switch cycle and the frame_done cycle inclusively.
        clear_mems();
        vb = valid_cnt;
        pulse_switch();
        wait_fd("t2_done", 200);
        tick();
        chk("t2_span",  val_t'(fd_cyc - sw_cyc + 1), val_t'(3 * 16 + 16 + 2));
        chk("t2_valid", val_t'(valid_cnt - vb),      val_t'(0));
        tick();

        // Backpressure on the first beat for 10 cycles.
        mem_a[3] = DW'(5);
        mem_b[9] = DW'(7);
        out_ready = 1'b0;
        bb = beats.size();
        pulse_switch();
        wait_valid("t3_valid", 50);
        d0 = out_data; n0 = out_node; a0 = mem_addr;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (out_data !== d0 || out_node !== n0 || mem_addr !== a0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("t3_stable",   val_t'(stable),   val_t'(1));
        chk("t3_addr",     val_t'(mem_addr), val_t'(3));
        chk("t3_node",     val_t'(out_node), val_t'(3));
        chk("t3_data",     val_t'(out_data), val_t'(5));
        out_ready = 1'b1;
        wait_fd("t3_done", 200);
        tick();
        chk("t3_beats", val_t'(beats.size() - bb), val_t'(2));
        check_beat("t3_b0", bb, 3, 5, 0);
        check_beat("t3_b1", bb + 1, 9, 7, 1);
        tick();

        // Second switch while reading node 5 aborts the scan.
        clear_mems();
        cb = clean_cnt; fb = fd_cnt; ob = ov_cnt;
        pulse_switch();
        n = 0;
        while (mem_addr != AW'(5) && n < 60) begin
            tick();
            n++;
        end
        chk("t4_addr5", val_t'(mem_addr), val_t'(5));
        chk("t4_clean_pre", val_t'(mem_clean), val_t'(0));
        pulse_switch();
        chk("t4_overrun", val_t'(overrun),  val_t'(1));
        chk("t4_restart", val_t'(mem_addr), val_t'(0));
        wait_fd("t4_done", 200);
        tick();
        chk("t4_clean", val_t'(clean_cnt - cb), val_t'(16));
        chk("t4_fd",    val_t'(fd_cnt - fb),    val_t'(1));
        chk("t4_ov",    val_t'(ov_cnt - ob),    val_t'(1));
        tick();

        // Switch during clean: clean completes, next scan starts directly.
        cb = clean_cnt; fb = fd_cnt; ob = ov_cnt;
        pulse_switch();
        n = 0;
        while (!mem_clean && n < 80) begin
            tick();
            n++;
        end
        chk("t5_in_clean", val_t'(mem_clean), val_t'(1));
        repeat (5) tick();
        pulse_switch();
        chk("t5_overrun",  val_t'(overrun),   val_t'(1));
        chk("t5_cleaning", val_t'(mem_clean), val_t'(1));
        wait_fd("t5_done1", 100);
        chk("t5_no_idle",  val_t'(mem_addr),  val_t'(0));
        chk("t5_clean_off", val_t'(mem_clean), val_t'(0));
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < 200);
        chk("t5_gap", val_t'(n), val_t'(64));
        tick();
        chk("t5_clean", val_t'(clean_cnt - cb), val_t'(32));
        chk("t5_fd",    val_t'(fd_cnt - fb),    val_t'(2));
        chk("t5_ov",    val_t'(ov_cnt - ob),    val_t'(1));
        tick();

        // Reset while a beat is pending in CHK_A.
        clear_mems();
        mem_a[3] = DW'(5);
        out_ready = 1'b0;
        pulse_switch();
        wait_valid("t6_valid", 50);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", val_t'(out_valid), val_t'(0));
        chk("t6_rst_data",  val_t'(out_data),  val_t'(0));
        chk("t6_rst_node",  val_t'(out_node),  val_t'(0));
        chk("t6_rst_addr",  val_t'(mem_addr),  val_t'(0));
        chk("t6_rst_clean", val_t'(mem_clean), val_t'(0));
        tick();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        fb = fd_cnt; vb = valid_cnt; cb = clean_cnt;
        repeat (40) tick();
        chk("t6_idle_valid", val_t'(valid_cnt - vb), val_t'(0));
        chk("t6_idle_fd",    val_t'(fd_cnt - fb),    val_t'(0));
        chk("t6_idle_clean", val_t'(clean_cnt - cb), val_t'(0));
        chk("t6_idle_addr",  val_t'(mem_addr),       val_t'(0));
        bb = beats.size();
        pulse_switch();
        wait_fd("t6_done", 200);
        tick();
        chk("t6_fd", val_t'(fd_cnt - fb), val_t'(1));
        chk("t6_beats", val_t'(beats.size() - bb), val_t'(1));
        check_beat("t6_b0", bb, 3, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
